xor16_descrambler: RTL and testbench
====================================

XOR16_DESCRAMBLER -- requirements
Module: xor16_descrambler

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, the replacement seed used whenever a zero seed is loaded.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port load, input, 1 bit: seed-load strobe.
REQ-005 SHALL have port seed_in, input, 16 bits: seed value captured when load is high.
REQ-006 SHALL have port in_valid, input, 1 bit: scrambled word is present.
REQ-007 SHALL have port in_data, input, 16 bits: scrambled word.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: descrambled word is held.
REQ-010 SHALL have port out_data, output, signed 16 bits: descrambled word.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port word_cnt, output, 16 bits: count of words accepted since the last load.

Function
REQ-013 SHALL implement a two-state FSM: UNSYNC (entered at reset) and RUN.
REQ-014 SHALL, in UNSYNC, hold in_ready=0; load=1 moves the FSM to RUN.
REQ-015 SHALL, on load=1 in any state, set lfsr<=seed_in, or lfsr<=SEED if seed_in==0, and set word_cnt<=0.
REQ-016 SHALL drive in_ready = (state==RUN) && !load && (!out_valid || out_ready).
REQ-017 SHALL define an input accept as in_valid && in_ready, and an output accept as out_valid && out_ready.
REQ-018 SHALL, on an input accept, register out_data <= in_data ^ lfsr and set out_valid=1.
REQ-019 SHALL give one-cycle latency from input accept to out_valid.
REQ-020 SHALL, on an input accept, step the LFSR once: fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5]; lfsr <= {fb, lfsr[15:1]}. This is the polynomial x^16+x^14+x^13+x^11+1.
REQ-021 SHALL, on an input accept, increment word_cnt modulo 2^16, wrapping from 16'hFFFF to 0.
REQ-022 SHALL clear out_valid on an output accept with no input accept in the same cycle.
REQ-023 SHALL, on simultaneous output and input accepts, load the new word with out_valid staying 1, so back-to-back throughput is one word per cycle.
REQ-024 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, when load is asserted while out_valid=1, keep the pending word, which is still delivered.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, set state=UNSYNC, lfsr=SEED, out_valid=0, out_data=0 and word_cnt=0.
REQ-027 SHALL give rst_n priority over load and over all handshakes.
REQ-028 SHALL drop any word pending at reset mid-stream.

Structure
REQ-029 SHALL place the FSM state encoding, the tap positions and the default seed 16'hACE1 in a shared package named descrambler_pkg.
REQ-030 SHALL split out one sub-module, lfsr16_step: combinational next-state only, 16 in, 16 out.
REQ-031 SHALL perform the keystream XOR with the existing 16-bit gate-level xor module.

Verification
REQ-032 SHALL cover reset then no load, with in_valid=1 for 10 cycles -> in_ready=0 throughout and out_valid=0.
REQ-033 SHALL cover load seed 16'hACE1, then words 16'h0000 and 16'hFFFF back-to-back with out_ready=1 -> out_data 16'hACE1 then 16'hA98F; word_cnt=2.
REQ-034 SHALL cover load seed 0, then word 16'h0000 -> out_data 16'hACE1, with the same result as seed ACE1.
REQ-035 SHALL cover out_ready=0 for 5 cycles with a word pending -> out_data is stable and in_ready=0; the following word is then delivered in order with keystream 16'h5670.
REQ-036 SHALL cover a reload mid-stream after 3 words -> the next word uses the new seed and word_cnt restarts at 1.
REQ-037 SHALL cover 65536 accepted words -> word_cnt wraps to 0, and the output matches a reference model XORing with the LFSR sequence.

Source files
------------

// File: rtl/descrambler_pkg.sv
// Shared definitions for the 16-bit XOR descrambler: state encoding, LFSR taps, default seed.
package descrambler_pkg;

    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // Feedback taps at bits 0,2,3,5 (x^16+x^14+x^13+x^11+1, right-shifting form)
    localparam logic [LFSR_W-1:0] TAP_MASK = 16'h002D;

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

endpackage

// File: rtl/xor16.sv
// 16-bit bitwise XOR built from gate primitives.
module xor16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);

    for (genvar g = 0; g < 16; g++) begin : g_bit
        xor u_xor (o_y[g], i_a[g], i_b[g]);
    end

endmodule

// File: rtl/xor16_descrambler_lfsr16_step.sv
// Combinational next-state of the 16-bit Fibonacci LFSR (one shift per call).
module lfsr16_step
    import descrambler_pkg::*;
(
    input  logic [LFSR_W-1:0] i_lfsr,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic w_fb;

    assign w_fb   = ^(i_lfsr & TAP_MASK);
    assign o_lfsr = {w_fb, i_lfsr[LFSR_W-1:1]};

endmodule

// File: rtl/xor16_descrambler.sv
// Additive descrambler: XORs each accepted 16-bit word with an LFSR keystream,
// one-word output register with valid/ready handshake on both sides.
module xor16_descrambler
    import descrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [LFSR_W-1:0]        seed_in,
    input  logic                     in_valid,
    input  logic [LFSR_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [LFSR_W-1:0] out_data,
    input  logic                     out_ready,
    output logic [LFSR_W-1:0]        word_cnt
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_in_ready;
    logic                w_in_accept;
    logic                w_out_accept;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [LFSR_W-1:0]   w_lfsr_nxt;
    logic [LFSR_W-1:0]   w_seed_eff;
    logic [LFSR_W-1:0]   w_plain;
    logic [LFSR_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic [LFSR_W-1:0]   r_word_cnt;

    lfsr16_step u_step (
        .i_lfsr (r_lfsr),
        .o_lfsr (w_lfsr_nxt)
    );

    xor16 u_xor (
        .i_a (in_data),
        .i_b (r_lfsr),
        .o_y (w_plain)
    );

    // An all-zero seed would lock the LFSR, so it is replaced by SEED
    assign w_seed_eff   = (seed_in == '0) ? SEED : seed_in;
    assign w_in_accept  = in_valid && w_in_ready;
    assign w_out_accept = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_UNSYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_UNSYNC: begin
                if (load) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_ready = !load && (!r_out_valid || out_ready);
            end
            default: begin
                w_state_nxt = ST_UNSYNC;
            end
        endcase
    end

    // Keystream, word counter and the single-entry output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr      <= SEED;
            r_word_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (load) begin
                r_lfsr     <= w_seed_eff;
                r_word_cnt <= '0;
            end else if (w_in_accept) begin
                r_lfsr     <= w_lfsr_nxt;
                r_word_cnt <= r_word_cnt + LFSR_W'(1);
            end
            if (w_in_accept) begin
                r_out_data  <= w_plain;
                r_out_valid <= 1'b1;
            end else if (w_out_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = $signed(r_out_data);
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_xor16_descrambler.sv
// Scoreboard bench for xor16_descrambler: cycle model predicts handshakes and keystream.
module tb_xor16_descrambler;

    localparam int unsigned W = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                load;
    logic [W-1:0]        seed_in;
    logic                in_valid;
    logic [W-1:0]        in_data;
    logic                in_ready;
    logic                out_valid;
    logic signed [W-1:0] out_data;
    logic                out_ready;
    logic [W-1:0]        word_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic         m_known = 1'b0;
    logic         m_run   = 1'b0;
    logic         m_ov    = 1'b0;
    logic [W-1:0] m_lfsr  = '0;
    logic [W-1:0] m_cnt   = '0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    xor16_descrambler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .seed_in   (seed_in),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // One clock: check combinational ready and popped output, advance model, check registers
    task automatic cycle();
        logic         exp_rdy;
        logic         in_acc;
        logic         out_acc;
        logic [W-1:0] exp_d;
        #1;
        exp_rdy = m_run && !load && (!m_ov || out_ready);
        in_acc  = in_valid && exp_rdy;
        out_acc = m_ov && out_ready;
        if (m_known) begin
            chk("in_ready", W'(in_ready), W'(exp_rdy));
            if (out_acc) begin
                chk("sb_depth", W'(exp_q.size()), W'(1));
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    chk("out_data", out_data, exp_d);
                end
            end
        end
        if (!rst_n) begin
            m_known = 1'b1;
            m_run   = 1'b0;
            m_ov    = 1'b0;
            m_lfsr  = 16'hACE1;
            m_cnt   = '0;
            exp_q.delete();
        end else begin
            if (out_acc && exp_q.size() > 0 && !m_known) void'(exp_q.pop_front());
            if (load) begin
                m_run  = 1'b1;
                m_lfsr = (seed_in == '0) ? 16'hACE1 : seed_in;
                m_cnt  = '0;
            end else if (in_acc) begin
                exp_q.push_back(in_data ^ m_lfsr);
                m_lfsr = ref_step(m_lfsr);
                m_cnt  = m_cnt + W'(1);
            end
            if (in_acc) m_ov = 1'b1;
            else if (out_acc) m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("out_valid", W'(out_valid), W'(m_ov));
            chk("word_cnt", word_cnt, m_cnt);
        end
    endtask

    task automatic drive(input logic l, input logic [W-1:0] s, input logic v,
                         input logic [W-1:0] d, input logic r);
        load      = l;
        seed_in   = s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0; seed_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;

        // No load after reset: nothing may be accepted
        repeat (10) drive(1'b0, '0, 1'b1, W'($urandom), 1'b1);
        chk("unsync_ov", W'(out_valid), W'(0));
        chk("unsync_cnt", word_cnt, W'(0));

        // Known keystream from seed ACE1
        drive(1'b1, 16'hACE1, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1, 16'h0000, 1'b1);
        chk("w0_ace1", out_data, 16'hACE1);
        drive(1'b0, '0, 1'b1, 16'hFFFF, 1'b1);
        chk("w1_a98f", out_data, 16'hA98F);
        chk("cnt_2", word_cnt, W'(2));
        drive(1'b0, '0, 1'b0, '0, 1'b1);

        // Zero seed substitutes the default
        drive(1'b1, 16'h0000, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1, 16'h0000, 1'b1);
        chk("seed0", out_data, 16'hACE1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);

        // Backpressure: pending word held, then next word in order
        drive(1'b1, 16'hACE1, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b1, 16'hFFFF, 1'b0);
            chk("hold_data", out_data, 16'hACE1);
        end
        drive(1'b0, '0, 1'b1, 16'hFFFF, 1'b1);
        chk("ks_5670", out_data ^ 16'hFFFF, 16'h5670);
        drive(1'b0, '0, 1'b0, '0, 1'b1);

        // Reload mid-stream with a word still pending
        drive(1'b1, 16'h1234, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, W'($urandom), 1'b1);
        drive(1'b1, 16'hBEEF, 1'b1, 16'h5555, 1'b0);
        chk("reload_keep", W'(out_valid), W'(1));
        drive(1'b0, '0, 1'b1, 16'h0000, 1'b1);
        chk("reseed", out_data, 16'hBEEF);
        chk("cnt_1", word_cnt, W'(1));

        // Reset mid-stream drops the pending word
        rst_n = 1'b0;
        drive(1'b1, 16'h7777, 1'b1, 16'h1111, 1'b0);
        rst_n = 1'b1;
        chk("rst_drop", W'(out_valid), W'(0));
        chk("rst_data", out_data, W'(0));

        // Full counter wrap against the reference keystream
        drive(1'b1, 16'h9D2C, 1'b0, '0, 1'b1);
        for (int i = 0; i < 65536; i++) drive(1'b0, '0, 1'b1, W'($urandom), 1'b1);
        chk("cnt_wrap", word_cnt, W'(0));
        drive(1'b0, '0, 1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
